// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// latency counter width and the captured-request record.
package dm_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dm_state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dm_req_t;

endpackage

// File: rtl/dm_responder_if.sv
// MEM-stage load/store port between the core (master) and the data-memory
// responder (slave): one request channel, one response channel.
interface dm_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane steering for the data memory: store byte enables and
// merged write word, load lane extraction with sign/zero extension, misalign flag.
module dm_lane_unit
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] old_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wr_word,
   output logic [31:0] rd_data,
   output logic        misalign
);

   function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
      logic signed [7:0]  b_s;
      logic signed [31:0] w_s;
      b_s = b;
      w_s = b_s;
      return s ? w_s : {24'd0, b};
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
      logic signed [15:0] h_s;
      logic signed [31:0] w_s;
      h_s = h;
      w_s = h_s;
      return s ? w_s : {16'd0, h};
   endfunction

   logic [31:0] wr_rep;

   always_comb begin
      byte_en  = 4'b1111;
      misalign = 1'b0;
      wr_rep   = wdata;
      rd_data  = old_word;
      wr_word  = old_word;
      case (size)
         SZ_BYTE: begin
            byte_en = 4'b0001 << addr_lo;
            wr_rep  = {4{wdata[7:0]}};
            rd_data = ext8(old_word[{addr_lo, 3'b000} +: 8], sign);
         end
         SZ_HALF: begin
            byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
            wr_rep   = {2{wdata[15:0]}};
            misalign = addr_lo[0];
            rd_data  = ext16(addr_lo[1] ? old_word[31:16] : old_word[15:0], sign);
         end
         default: begin
            // size 3 decodes as a word access
            misalign = (addr_lo != 2'b00);
         end
      endcase
      // Replicated store data lands in whichever lanes are enabled
      for (int i = 0; i < 4; i++) begin
         wr_word[8*i +: 8] = byte_en[i] ? wr_rep[8*i +: 8] : old_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time, response LATENCY cycles after accept.
// Optional build macro DM_ALIGN_CHECK_EN flags and suppresses misaligned half/word accesses.
module dm_responder
   import dm_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2     // legal range 1..15 (fits the 4-bit counter)
) (
   input  logic          clk,
   input  logic          reset,
   dm_responder_if.slave bus
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   dm_state_e        state;
   dm_state_e        state_nxt;
   logic [CNT_W-1:0] cnt_q;
   dm_req_t          req_q;
   dm_req_t          req_live;
   dm_req_t          req_act;
   logic [31:0]      mem [DEPTH];
   logic             accept;
   logic             commit;
   logic             bad;
   logic [IDX_W-1:0] idx;
   logic [3:0]       byte_en;
   logic [31:0]      wr_word;
   logic [31:0]      rd_data;
   logic             misalign;
   logic [31:0]      resp_rdata_q;
   logic             resp_err_q;

   assign req_live = {bus.req_we, bus.req_size, bus.req_sign, bus.req_addr, bus.req_wdata};
   assign accept   = bus.req_valid && bus.req_ready;

   // With single-cycle latency the access happens on the accept edge, so it
   // must work from the live request rather than the captured one.
   assign req_act = (LATENCY == 1) ? req_live : req_q;
   assign idx     = req_act.addr[ADDR_WIDTH-1:2];

   dm_lane_unit u_lane (
      .size     (req_act.size),
      .sign     (req_act.sign),
      .addr_lo  (req_act.addr[1:0]),
      .wdata    (req_act.wdata),
      .old_word (mem[idx]),
      .byte_en  (byte_en),
      .wr_word  (wr_word),
      .rd_data  (rd_data),
      .misalign (misalign)
   );

`ifdef DM_ALIGN_CHECK_EN
   assign bad = misalign;
   logic unused_bits;
   assign unused_bits = ^req_act.addr[31:ADDR_WIDTH];
`else
   assign bad = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{req_act.addr[31:ADDR_WIDTH], misalign};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      commit         = 1'b0;
      case (state)
         ST_WAIT: begin
            // Commit on the edge where the counter steps down to zero
            if (cnt_q == CNT_W'(1)) begin
               commit    = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         default: begin
            bus.req_ready  = 1'b1;
            bus.resp_valid = (state == ST_RESP);
            if (bus.req_valid) begin
               if (LATENCY == 1) begin
                  commit    = 1'b1;
                  state_nxt = ST_RESP;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= CNT_LOAD;
      end else if (state == ST_WAIT) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         req_q <= req_live;
      end
   end

   // Memory and response registers; reset clears the whole array, so an
   // abandoned store can never leave a trace.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else if (commit) begin
         if (req_act.we && !bad) begin
            for (int b = 0; b < 4; b++) begin
               if (byte_en[b]) begin
                  mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
               end
            end
         end
         resp_rdata_q <= (req_act.we || bad) ? 32'd0 : rd_data;
         resp_err_q   <= bad;
      end
   end

   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder at LATENCY 2, 1 and 3 with a response scoreboard
// that also checks the exact response cycle of every accepted request.
module tb_dm_responder;
   import dm_pkg::*;

   logic clk;
   logic reset;

   dm_responder_if ifa ();
   dm_responder_if ifb ();
   dm_responder_if ifc ();

   dm_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut_l2 (.clk(clk), .reset(reset), .bus(ifa));
   dm_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u_dut_l1 (.clk(clk), .reset(reset), .bus(ifb));
   dm_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u_dut_l3 (.clk(clk), .reset(reset), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int d);
      case (d)
         0:       return ifa.req_ready;
         1:       return ifb.req_ready;
         default: return ifc.req_ready;
      endcase
   endfunction

   function automatic int lat(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int qlen(input int d);
      case (d)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   task automatic drv(input int d, input logic v, input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd);
      case (d)
         0: begin
            ifa.req_valid = v; ifa.req_we = we; ifa.req_size = sz;
            ifa.req_sign = sg; ifa.req_addr = a; ifa.req_wdata = wd;
         end
         1: begin
            ifb.req_valid = v; ifb.req_we = we; ifb.req_size = sz;
            ifb.req_sign = sg; ifb.req_addr = a; ifb.req_wdata = wd;
         end
         default: begin
            ifc.req_valid = v; ifc.req_we = we; ifc.req_size = sz;
            ifc.req_sign = sg; ifc.req_addr = a; ifc.req_wdata = wd;
         end
      endcase
   endtask

   task automatic idle(input int d);
      drv(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic mon_one(input int d);
      logic        v;
      logic [31:0] r;
      logic        e;
      exp_t        x;
      v = 1'b0; r = '0; e = 1'b0;
      case (d)
         0:       begin v = ifa.resp_valid; r = ifa.resp_rdata; e = ifa.resp_err; end
         1:       begin v = ifb.resp_valid; r = ifb.resp_rdata; e = ifb.resp_err; end
         default: begin v = ifc.resp_valid; r = ifc.resp_rdata; e = ifc.resp_err; end
      endcase
      if (v === 1'b1) begin
         if (qlen(d) == 0) begin
            chk($sformatf("unexpected_resp_dut%0d", d), 32'(v), 32'd0);
         end else begin
            case (d)
               0:       x = qa.pop_front();
               1:       x = qb.pop_front();
               default: x = qc.pop_front();
            endcase
            chk({x.tag, "_rdata"}, r, x.rdata);
            chk({x.tag, "_err"}, 32'(e), 32'(x.err));
            chk({x.tag, "_cycle"}, 32'(cyc), 32'(x.due));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int d = 0; d < 3; d++) mon_one(d);
   endtask

   // Present a request (valid stays high afterwards) and wait for its accept edge.
   task automatic issue(input int d, input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, output int acc);
      int   n;
      exp_t x;
      n = 0;
      drv(d, 1'b1, we, sz, sg, a, wd);
      while (rdy(d) !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_accept"}, 32'(rdy(d)), 32'd1);
      acc     = cyc + 1;
      x.tag   = tag;
      x.rdata = er;
      x.err   = ee;
      x.due   = acc + lat(d) - 1;
      case (d)
         0:       qa.push_back(x);
         1:       qb.push_back(x);
         default: qc.push_back(x);
      endcase
      tick();
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      idle(d);
      while (qlen(d) != 0 && n < 40) begin
         tick();
         n++;
      end
      chk($sformatf("drain_dut%0d", d), 32'(qlen(d)), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      int t0;
      int t1;
      reset = 1'b1;
      for (int d = 0; d < 3; d++) idle(d);
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;

      chk("rst_ready_l2", 32'(ifa.req_ready), 32'd1);
      chk("rst_rvalid_l2", 32'(ifa.resp_valid), 32'd0);
      chk("rst_rdata_l2", ifa.resp_rdata, 32'd0);
      chk("rst_err_l2", 32'(ifa.resp_err), 32'd0);
      chk("rst_ready_l1", 32'(ifb.req_ready), 32'd1);
      chk("rst_ready_l3", 32'(ifc.req_ready), 32'd1);

      // Word store then load; ready drops only while waiting
      issue(0, "st_w10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, t0);
      idle(0);
      chk("wait_ready_l2", 32'(rdy(0)), 32'd0);
      tick();
      chk("resp_ready_l2", 32'(rdy(0)), 32'd1);
      issue(0, "ld_w10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, t1);
      drain(0);

      // Byte store, signed/unsigned byte loads, word view (held valid)
      issue(0, "st_b13", 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hAAAAAA80, 32'h0, 1'b0, t0);
      issue(0, "ld_bs13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, t1);
      chk("b2b_spacing_l2", 32'(t1 - t0), 32'd2);
      issue(0, "ld_bu13", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, t0);
      issue(0, "ld_w10b", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h80345678, 1'b0, t0);
      drain(0);

      // Half store keeps the other half; lane extraction on halves and bytes
      issue(0, "st_w20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hA5A5C3C3, 32'h0, 1'b0, t0);
      issue(0, "st_h22", 1'b1, SZ_HALF, 1'b0, 32'h22, 32'hDEADBEEF, 32'h0, 1'b0, t0);
      issue(0, "ld_hs22", 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, t0);
      issue(0, "ld_w20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hBEEFC3C3, 1'b0, t0);
      issue(0, "ld_hu20", 1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 32'h0000C3C3, 1'b0, t0);
      issue(0, "ld_bu21", 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 32'h000000C3, 1'b0, t0);
      issue(0, "ld_bs22", 1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0, 32'hFFFFFFEF, 1'b0, t0);
      drain(0);

      // LATENCY 1: one access per cycle, load sees the store just before it
      issue(1, "l1_st_w44", 1'b1, SZ_WORD, 1'b0, 32'h44, 32'hCAFEF00D, 32'h0, 1'b0, t0);
      issue(1, "l1_ld_w44", 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 1'b0, t1);
      chk("b2b_spacing_l1", 32'(t1 - t0), 32'd1);
      issue(1, "l1_st_b45", 1'b1, SZ_BYTE, 1'b0, 32'h45, 32'h0000007F, 32'h0, 1'b0, t0);
      issue(1, "l1_ld_w44b", 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, 32'hCAFE7F0D, 1'b0, t0);
      issue(1, "l1_ld_bs45", 1'b0, SZ_BYTE, 1'b1, 32'h45, 32'h0, 32'h0000007F, 1'b0, t0);
      drain(1);

      // LATENCY 3: one access per three cycles
      issue(2, "l3_st_h52", 1'b1, SZ_HALF, 1'b0, 32'h52, 32'h00008001, 32'h0, 1'b0, t0);
      issue(2, "l3_ld_hs52", 1'b0, SZ_HALF, 1'b1, 32'h52, 32'h0, 32'hFFFF8001, 1'b0, t1);
      chk("b2b_spacing_l3", 32'(t1 - t0), 32'd3);
      issue(2, "l3_ld_w50", 1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0, 32'h80010000, 1'b0, t0);
      drain(2);

      // Reset while a store waits: no response, store never lands
      issue(0, "st_w30_abort", 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h77777777, 32'h0, 1'b0, t0);
      idle(0);
      chk("abort_in_wait", 32'(rdy(0)), 32'd0);
      reset = 1'b1;
      qa.delete();
      tick();
      reset = 1'b0;
      chk("abort_ready", 32'(rdy(0)), 32'd1);
      chk("abort_rvalid", 32'(ifa.resp_valid), 32'd0);
      tick();
      tick();
      issue(0, "ld_w30", 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, t0);
      drain(0);

      // Misaligned word accesses
      issue(0, "st_w40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, t0);
`ifdef DM_ALIGN_CHECK_EN
      issue(0, "st_w41_mis", 1'b1, SZ_WORD, 1'b0, 32'h41, 32'h55667788, 32'h0, 1'b1, t0);
      issue(0, "ld_w40_keep", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, t0);
      issue(0, "ld_w42_mis", 1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, t0);
      issue(0, "ld_h41_mis", 1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, t0);
`else
      issue(0, "st_w41", 1'b1, SZ_WORD, 1'b0, 32'h41, 32'h55667788, 32'h0, 1'b0, t0);
      issue(0, "ld_w40_new", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h55667788, 1'b0, t0);
      issue(0, "ld_w42", 1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0, 32'h55667788, 1'b0, t0);
      issue(0, "ld_hu41", 1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, 32'h00007788, 1'b0, t0);
`endif
      drain(0);

      for (int d = 0; d < 3; d++) drain(d);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
